restoring_divider: RTL and testbench

Sequential unsigned integer divider: the inverse of the lab's carry-lookahead adder, computing quotient and remainder by repeated trial subtraction, one quotient bit per clock. It sits beside the adder in the arithmetic datapath and serves any unit needing `a / b` and `a % b` without a combinational array divider. It uses a start/busy/done handshake and holds its results until the next operation is accepted.

---
 rtl/div_pkg.sv | 18 +
 rtl/sub_borrow.sv | 47 ++++
 rtl/restoring_divider.sv | 131 +++++++++++++
 tb/tb_restoring_divider.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding, default width
// and the iteration-counter sizing helper.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Counter must hold the value WIDTH itself, not just WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sub_borrow.sv
// N-bit subtractor a - b with lookahead borrow built from per-bit generate/propagate,
// mirroring the structure of the carry-lookahead adder.
module sub_borrow #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow_out
);

    logic [N-1:0] gen;
    logic [N-1:0] prop;
    logic [N:0]   borrow;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_bit
            assign gen[gi]  = ~a[gi] & b[gi];
            assign prop[gi] = ~(a[gi] ^ b[gi]);
            assign diff[gi] = ~prop[gi] ^ borrow[gi];
        end
    endgenerate

    // Borrow into bit i+1 is any lower generate whose borrow propagates up through bit i.
    always_comb begin
        logic term;
        logic acc;
        borrow = '0;
        term   = 1'b0;
        acc    = 1'b0;
        for (int i = 0; i < N; i++) begin
            acc = 1'b0;
            for (int j = 0; j <= i; j++) begin
                term = gen[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & prop[k];
                end
                acc = acc | term;
            end
            borrow[i+1] = acc;
        end
    end

    assign borrow_out = borrow[N];

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips CALC and completes right after acceptance.
module restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH:0]   r_reg;
    logic [CW-1:0]    cnt_reg;
    logic             div_zero_reg;

    logic             accept;
    logic             last_step;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial_diff;
    logic             trial_borrow;
    logic             r_msb_unused;

    assign accept    = start && (state_reg != CALC);
    assign last_step = (state_reg == CALC) && (cnt_reg == CNT_ONE);

    // The stored remainder is always below the divisor, so its top bit is zero before each shift.
    assign r_shift      = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    assign r_msb_unused = r_reg[WIDTH];

    sub_borrow #(
        .N(WIDTH + 1)
    ) u_trial (
        .a          (r_shift),
        .b          ({1'b0, d_reg}),
        .diff       (trial_diff),
        .borrow_out (trial_borrow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
`ifdef DIV_ZERO_FAST_EN
                    state_next = (divisor == '0) ? DONE : CALC;
`else
                    state_next = CALC;
`endif
                end else begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                if (cnt_reg == CNT_ONE) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            CALC:    busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg        <= '0;
            r_reg        <= '0;
            d_reg        <= '0;
            cnt_reg      <= '0;
            div_zero_reg <= 1'b0;
        end else if (accept) begin
            d_reg        <= divisor;
            q_reg        <= dividend;
            r_reg        <= '0;
            cnt_reg      <= CNT_LOAD;
            div_zero_reg <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
            if (divisor == '0) begin
                q_reg        <= '1;
                r_reg        <= {1'b0, dividend};
                cnt_reg      <= '0;
                div_zero_reg <= 1'b1;
            end
`endif
        end else if (state_reg == CALC) begin
            cnt_reg <= cnt_reg - CNT_ONE;
            q_reg   <= {q_reg[WIDTH-2:0], ~trial_borrow};
            r_reg   <= trial_borrow ? r_shift : trial_diff;
            if (last_step) begin
                div_zero_reg <= (d_reg == '0);
            end
        end
    end

    assign quotient  = q_reg;
    assign remainder = r_reg[WIDTH-1:0];
    assign div_zero  = div_zero_reg;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed and exhaustive self-checking bench for restoring_divider at WIDTH=4.
module tb_restoring_divider;

    localparam int WIDTH = 4;
`ifdef DIV_ZERO_FAST_EN
    localparam int ZERO_LAT = 0;
`else
    localparam int ZERO_LAT = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    int checks   = 0;
    int failures = 0;

    restoring_divider #(
        .WIDTH(WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after acceptance until done is seen; bounded so a stuck DUT still terminates.
    task automatic wait_done(input bit hold_start, output int lat, output int busy_cycles);
        lat         = 0;
        busy_cycles = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cycles++;
            start = hold_start;
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic check_result(input string tag, input int eq, input int er, input int edz,
                                input int elat, input int lat, input int bc);
        $display("op %s: q=%0d r=%0d dz=%0d lat=%0d busy_cycles=%0d",
                 tag, quotient, remainder, div_zero, lat, bc);
        check({tag, " latency"}, lat, elat);
        check({tag, " busy_cycles"}, bc, elat);
        check({tag, " busy_at_done"}, busy, 0);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " div_zero"}, div_zero, edz);
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int eq, input int er, input int edz, input int elat,
                          input bit check_hold);
        int lat;
        int bc;
        start_op(a, b);
        wait_done(1'b0, lat, bc);
        check_result(tag, eq, er, edz, elat, lat, bc);
        if (check_hold) begin
            @(posedge clk);
            #1;
            check({tag, " done_one_cycle"}, done, 0);
            check({tag, " held_quotient"}, quotient, eq);
            check({tag, " held_remainder"}, remainder, er);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int bc;
        int pulses;
        int eq;
        int er;
        int edz;
        int elat;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset div_zero", div_zero, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("13/3", 4'd13, 4'd3, 4, 1, 0, WIDTH, 1'b1);

        // Second operation issued during the DONE cycle of the first.
        start_op(4'd15, 4'd1);
        wait_done(1'b0, lat, bc);
        check_result("15/1", 15, 0, 0, WIDTH, lat, bc);
        start_op(4'd7, 4'd9);
        check("b2b done_cleared", done, 0);
        check("b2b busy_set", busy, 1);
        wait_done(1'b0, lat, bc);
        check_result("7/9 b2b", 0, 7, 0, WIDTH, lat, bc);
        @(posedge clk);
        #1;

        run_op("9/0", 4'd9, 4'd0, 15, 9, 1, ZERO_LAT, 1'b1);

        // start held high with different operands throughout a running 12/5.
        start_op(4'd12, 4'd5);
        dividend = 4'd15;
        divisor  = 4'd1;
        wait_done(1'b1, lat, bc);
        check_result("12/5 start_held", 2, 2, 0, WIDTH, lat, bc);
        pulses = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("12/5 extra_done", pulses, 0);
        check("12/5 idle_after", busy, 0);
        check("12/5 held_quotient", quotient, 2);

        // Asynchronous reset in the second CALC cycle.
        start_op(4'd13, 4'd3);
        @(posedge clk);
        #1;
        check("midcalc busy_before", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midcalc_rst busy", busy, 0);
        check("midcalc_rst done", done, 0);
        check("midcalc_rst quotient", quotient, 0);
        check("midcalc_rst remainder", remainder, 0);
        check("midcalc_rst div_zero", div_zero, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done || busy) pulses++;
        end
        check("midcalc_rst abandoned", pulses, 0);
        run_op("6/2 after_rst", 4'd6, 4'd2, 3, 0, 0, WIDTH, 1'b1);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) begin
                    eq   = 15;
                    er   = a;
                    edz  = 1;
                    elat = ZERO_LAT;
                end else begin
                    eq   = a / b;
                    er   = a % b;
                    edz  = 0;
                    elat = WIDTH;
                end
                run_op($sformatf("sweep %0d/%0d", a, b), WIDTH'(a), WIDTH'(b),
                       eq, er, edz, elat, 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
